// File: rtl/mirror_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mirror_pkg
// Description : Shared types and elaboration helpers for the mirror compare
//               scheduler (state encoding, index width, chunking check).
// Revision    : 1.0 - initial release
// ============================================================================
package mirror_pkg;

    // Scheduler states with an explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width needed to index n items; never less than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when n splits into whole chunks of the given width
    function automatic bit chunk_ok(input int n, input int chunk);
        return (chunk > 0) && (n >= chunk) && ((n % chunk) == 0);
    endfunction

endpackage : mirror_pkg
`default_nettype wire

// File: rtl/mirror_slice_eq.sv
`default_nettype none
// ============================================================================
// Module      : mirror_slice_eq
// Description : Combinational CHUNK-wide equality slice. Reports whether the
//               two chunks match and the offset of the lowest differing bit.
// Revision    : 1.0 - initial release
// ============================================================================
module mirror_slice_eq
    import mirror_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]             i_a,
    input  logic [CHUNK-1:0]             i_b,
    output logic                         o_eq,
    output logic [idx_width(CHUNK)-1:0]  o_off
);

    localparam int c_off_w = idx_width(CHUNK);

    logic [CHUNK-1:0] w_diff;

    assign w_diff = i_a ^ i_b;

    // Equality flag and priority encoder: the lowest set diff bit wins
    always_comb begin
        o_eq  = (w_diff == '0);
        o_off = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (w_diff[i]) begin
                o_off = c_off_w'(i);
            end
        end
    end

endmodule : mirror_slice_eq
`default_nettype wire

// File: rtl/mirror_cmp_sched.sv
`default_nettype none
// ============================================================================
// Module      : mirror_cmp_sched
// Description : Sequential mirror checker. Sweeps two N-bit vectors chunk by
//               chunk through one shared equality slice, reports verdict and
//               lowest mismatching bit, and keeps saturating pass/fail counts.
// Revision    : 1.0 - initial release
// ============================================================================
module mirror_cmp_sched
    import mirror_pkg::*;
#(
    parameter int N          = 20,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_eq,
    output logic [idx_width(N)-1:0]  out_idx,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt
);

    localparam int c_k     = N / CHUNK;
    localparam int c_ptr_w = idx_width(c_k);
    localparam int c_idx_w = idx_width(N);
    localparam int c_off_w = idx_width(CHUNK);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(c_k - 1);

    // Refuse to elaborate when the vector does not split into whole chunks
    if (!chunk_ok(N, CHUNK)) begin : g_bad_cfg
        $error("mirror_cmp_sched: N must be a non-zero multiple of CHUNK");
    end

    state_t               state_q, state_d;
    logic [N-1:0]         a_q, a_d;
    logic [N-1:0]         b_q, b_d;
    logic [c_ptr_w-1:0]   ptr_q, ptr_d;
    logic                 mism_q, mism_d;
    logic [c_idx_w-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]     pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]     fail_cnt_q, fail_cnt_d;

    logic [CHUNK-1:0]     w_a_chunk;
    logic [CHUNK-1:0]     w_b_chunk;
    logic                 w_chunk_eq;
    logic [c_off_w-1:0]   w_chunk_off;
    logic [c_idx_w-1:0]   w_idx_new;
    logic                 w_done;

    // Route the chunk selected by ptr onto the shared slice
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < c_k; k++) begin
            if (ptr_q == c_ptr_w'(k)) begin
                w_a_chunk = a_q[k*CHUNK +: CHUNK];
                w_b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    mirror_slice_eq #(
        .CHUNK (CHUNK)
    ) u_slice (
        .i_a   (w_a_chunk),
        .i_b   (w_b_chunk),
        .o_eq  (w_chunk_eq),
        .o_off (w_chunk_off)
    );

    assign w_idx_new = c_idx_w'(ptr_q) * c_idx_w'(CHUNK) + c_idx_w'(w_chunk_off);

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            ptr_q      <= '0;
            mism_q     <= 1'b0;
            idx_q      <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ptr_q      <= ptr_d;
            mism_q     <= mism_d;
            idx_q      <= idx_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Next-state logic: accept, sweep chunks, deliver; flush always wins
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        ptr_d      = ptr_q;
        mism_d     = mism_q;
        idx_d      = idx_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!flush && in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    ptr_d   = '0;
                    mism_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    // Only the first mismatch records an index
                    if (!w_chunk_eq && !mism_q) begin
                        mism_d = 1'b1;
                        idx_d  = w_idx_new;
                    end
                    if ((EARLY_EXIT != 0) && !w_chunk_eq) begin
                        state_d = ST_DONE;
                    end else if (ptr_q == c_last_ptr) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_q + c_ptr_w'(1);
                    end
                end
            end
            ST_DONE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    if (mism_q) begin
                        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
                    end else begin
                        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: handshake flags from state, result fields visible only in DONE
    always_comb begin
        w_done    = (state_q == ST_DONE);
        in_ready  = (state_q == ST_IDLE) && rst_n;
        out_valid = w_done;
        out_eq    = w_done && !mism_q;
        out_idx   = w_done ? idx_q : '0;
        pass_cnt  = pass_cnt_q;
        fail_cnt  = fail_cnt_q;
    end

endmodule : mirror_cmp_sched
`default_nettype wire

// File: tb/tb_mirror_cmp_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mirror_cmp_sched
// Description : Self-checking bench. Three scheduler instances (early exit,
//               full sweep, 2-bit counters) share one stimulus stream and are
//               checked every cycle against a transaction-level model, plus
//               hand-computed expectations for the directed jobs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mirror_cmp_sched;

    localparam int N     = 20;
    localparam int CHUNK = 4;
    localparam int K     = N / CHUNK;
    localparam int NI    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;

    logic        ee_rdy, ee_vld, ee_eq;  logic [4:0] ee_idx; logic [15:0] ee_p, ee_f;
    logic        fs_rdy, fs_vld, fs_eq;  logic [4:0] fs_idx; logic [15:0] fs_p, fs_f;
    logic        st_rdy, st_vld, st_eq;  logic [4:0] st_idx; logic [1:0]  st_p, st_f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mirror_cmp_sched #(.N(N), .CHUNK(CHUNK), .EARLY_EXIT(1), .CNT_W(16)) u_ee (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ee_rdy),
        .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(ee_vld),
        .out_ready(out_ready), .out_eq(ee_eq), .out_idx(ee_idx),
        .pass_cnt(ee_p), .fail_cnt(ee_f));

    mirror_cmp_sched #(.N(N), .CHUNK(CHUNK), .EARLY_EXIT(0), .CNT_W(16)) u_fs (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(fs_rdy),
        .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(fs_vld),
        .out_ready(out_ready), .out_eq(fs_eq), .out_idx(fs_idx),
        .pass_cnt(fs_p), .fail_cnt(fs_f));

    mirror_cmp_sched #(.N(N), .CHUNK(CHUNK), .EARLY_EXIT(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(st_rdy),
        .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(st_vld),
        .out_ready(out_ready), .out_eq(st_eq), .out_idx(st_idx),
        .pass_cnt(st_p), .fail_cnt(st_f));

    // ---------------- transaction-level model ----------------
    // m_st: 0 = waiting for a job, 1 = busy for m_left more edges, 2 = result held
    int m_st   [NI];
    int m_left [NI];
    int m_eq   [NI];
    int m_idx  [NI];
    int m_pass [NI];
    int m_fail [NI];
    int acc_edge  [NI];
    int rise_edge [NI];
    int rise_eq   [NI];
    int rise_idx  [NI];
    int prev_vld  [NI];
    int cyc = 0;
    int ee_of  [NI] = '{1, 0, 1};
    int cmax   [NI] = '{65535, 65535, 3};

    function automatic int first_diff(input logic [N-1:0] a, input logic [N-1:0] b);
        for (int k = 0; k < N; k++) begin
            if (a[k] != b[k]) return k;
        end
        return -1;
    endfunction

    // Latency rule: mismatch with early exit stops after its chunk, else full sweep
    function automatic int job_latency(input logic [N-1:0] a, input logic [N-1:0] b, input int ee);
        int d;
        d = first_diff(a, b);
        if (d >= 0 && ee != 0) return d / CHUNK + 1;
        return K;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_st[i]   <= 0;
                m_pass[i] <= 0;
                m_fail[i] <= 0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < NI; i++) begin
                case (m_st[i])
                    0: if (!flush && in_valid) begin
                        m_eq[i]     <= (in_a == in_b) ? 1 : 0;
                        m_idx[i]    <= (in_a == in_b) ? 0 : first_diff(in_a, in_b);
                        m_left[i]   <= job_latency(in_a, in_b, ee_of[i]);
                        m_st[i]     <= 1;
                        acc_edge[i] <= cyc + 1;
                    end
                    1: if (flush) m_st[i] <= 0;
                       else if (m_left[i] == 1) m_st[i] <= 2;
                       else m_left[i] <= m_left[i] - 1;
                    default: if (flush) m_st[i] <= 0;
                       else if (out_ready) begin
                           m_st[i] <= 0;
                           if (m_eq[i] != 0) m_pass[i] <= (m_pass[i] < cmax[i]) ? m_pass[i] + 1 : m_pass[i];
                           else              m_fail[i] <= (m_fail[i] < cmax[i]) ? m_fail[i] + 1 : m_fail[i];
                       end
                endcase
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < NI; i++) prev_vld[i] = 0;
            end else begin
                for (int i = 0; i < NI; i++) begin
                    int av, ar, ae, ai, ap, af;
                    case (i)
                        0: begin av = ee_vld; ar = ee_rdy; ae = ee_eq; ai = ee_idx; ap = ee_p; af = ee_f; end
                        1: begin av = fs_vld; ar = fs_rdy; ae = fs_eq; ai = fs_idx; ap = fs_p; af = fs_f; end
                        default: begin av = st_vld; ar = st_rdy; ae = st_eq; ai = st_idx; ap = st_p; af = st_f; end
                    endcase
                    chk($sformatf("u%0d_out_valid", i), av, (m_st[i] == 2) ? 1 : 0);
                    chk($sformatf("u%0d_in_ready", i), ar, (m_st[i] == 0) ? 1 : 0);
                    if (m_st[i] == 2) begin
                        chk($sformatf("u%0d_out_eq", i), ae, m_eq[i]);
                        chk($sformatf("u%0d_out_idx", i), ai, m_idx[i]);
                    end
                    chk($sformatf("u%0d_pass_cnt", i), ap, m_pass[i]);
                    chk($sformatf("u%0d_fail_cnt", i), af, m_fail[i]);
                    if (av != 0 && prev_vld[i] == 0) begin
                        rise_edge[i] = cyc;
                        rise_eq[i]   = ae;
                        rise_idx[i]  = ai;
                    end
                    prev_vld[i] = av;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_all_idle();
        int t = 0;
        while (!(ee_rdy && fs_rdy && st_rdy) && t < 40) begin
            step();
            t++;
        end
        if (t >= 40) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_all_valid();
        int t = 0;
        while (!(ee_vld && fs_vld && st_vld) && t < 30) begin
            step();
            t++;
        end
        if (t >= 30) chk("valid_timeout", 0, 1);
    endtask

    // Offer one job, scramble the inputs after acceptance, hold out_ready low for 'hold' cycles
    task automatic run_job(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
        wait_all_idle();
        in_valid = 1'b1; in_a = a; in_b = b;
        step();
        in_valid = 1'b0; in_a = ~a; in_b = b ^ 20'h5A5A5;
        wait_all_valid();
        for (int h = 0; h < hold; h++) begin
            chk("bp_in_ready", ee_rdy, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", ee_vld, 0);
        chk("rst_out_idx", ee_idx, 0);
        chk("rst_pass", ee_p, 0);
        chk("rst_in_ready", ee_rdy, 1);
        step();

        // Equal vectors: full sweep, eq=1, idx=0
        run_job(20'hABCDE, 20'hABCDE, 0);
        chk("eq_latency_ee", rise_edge[0] - acc_edge[0], 5);
        chk("eq_latency_fs", rise_edge[1] - acc_edge[1], 5);
        chk("eq_out_eq", rise_eq[0], 1);
        chk("eq_out_idx", rise_idx[0], 0);
        chk("eq_pass_cnt", ee_p, 1);

        // Single mismatch at bit 8: early exit after chunk 2
        run_job(20'h00000, 20'h00100, 0);
        chk("b8_latency_ee", rise_edge[0] - acc_edge[0], 3);
        chk("b8_latency_fs", rise_edge[1] - acc_edge[1], 5);
        chk("b8_out_idx", rise_idx[0], 8);
        chk("b8_out_eq", rise_eq[0], 0);
        chk("b8_fail_cnt", ee_f, 1);

        // Bits 3 and 17 differ: lowest wins, full sweep keeps the first index
        run_job(20'h00000, 20'h20008, 0);
        chk("b3_latency_fs", rise_edge[1] - acc_edge[1], 5);
        chk("b3_latency_ee", rise_edge[0] - acc_edge[0], 1);
        chk("b3_out_idx_fs", rise_idx[1], 3);
        chk("b3_fail_cnt_fs", fs_f, 2);

        // Backpressure for 4 cycles
        run_job(20'h12345, 20'h12345, 4);
        chk("bp_pass_cnt", ee_p, 2);
        chk("bp_fail_cnt", ee_f, 2);

        // Flush while comparing (sampled at e0+2)
        wait_all_idle();
        in_valid = 1'b1; in_a = 20'hABCDE; in_b = 20'hABCDE;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_cmp_in_ready", ee_rdy, 1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            seen = seen | ee_vld | fs_vld | st_vld;
            step();
        end
        chk("flush_cmp_no_valid", seen, 0);
        chk("flush_cmp_pass", ee_p, 2);

        // Flush and out_ready together in DONE: result discarded
        wait_all_idle();
        in_valid = 1'b1; in_a = 20'h00001; in_b = 20'h00001;
        step();
        in_valid = 1'b0;
        wait_all_valid();
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_done_valid", fs_vld, 0);
        chk("flush_done_pass", fs_p, 2);

        // Flush in IDLE blocks acceptance
        flush = 1'b1; in_valid = 1'b1; in_a = 20'h0000F; in_b = 20'h00000;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_ready", ee_rdy, 1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            seen = seen | ee_vld | fs_vld | st_vld;
            step();
        end
        chk("flush_idle_no_valid", seen, 0);

        // Reset mid-compare
        in_valid = 1'b1; in_a = 20'hFFFFF; in_b = 20'hFFFFF;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", ee_vld, 0);
        chk("midrst_pass", ee_p, 0);
        chk("midrst_fail", ee_f, 0);
        chk("midrst_fs_fail", fs_f, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("midrst_ready", ee_rdy, 1);
        step();

        // Saturation on the 2-bit counter instance
        for (int j = 0; j < 5; j++) run_job(20'h0F0F0, 20'h0F0F0, 0);
        chk("sat_pass_cnt", st_p, 3);
        chk("sat_fail_cnt", st_f, 0);
        chk("sat_ref_pass", ee_p, 5);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mirror_cmp_sched
`default_nettype wire

// File: doc/mirror_cmp_sched.md
Name: mirror_cmp_sched

Overview:
- Sequential scheduler that checks whether two N-bit vectors mirror each other (a[k]==b[k] for all k).
- Shares one CHUNK-wide equality slice across successive chunks, sweeping from chunk 0 upward.
- Returns a verdict plus the lowest mismatching bit index, and keeps pass/fail statistics.
- Sits between a requester issuing compare jobs over valid/ready and a consumer of results.

Parameters:
- N, 20, width of each compared vector; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 4, bits compared per cycle by the shared slice.
- EARLY_EXIT, 1, 1 = stop at the first mismatching chunk; 0 = always sweep all chunks.
- CNT_W, 16, width of the saturating pass/fail counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  scheduler can accept a job.
- in_a  in  N  first vector.
- in_b  in  N  second vector.
- flush  in  1  synchronous abort of the current job.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_eq  out  1  1 = vectors mirror exactly.
- out_idx  out  $clog2(N)  lowest mismatching bit index; 0 when out_eq=1.
- pass_cnt  out  CNT_W  saturating count of delivered eq=1 results.
- fail_cnt  out  CNT_W  saturating count of delivered eq=0 results.

Behaviour:
- K = N/CHUNK. FSM states: IDLE, CMP, DONE. Registers: a_q, b_q, ptr (0..K-1), mism (sticky), idx_q.
- Reset (rst_n low, async): state=IDLE, ptr=0, mism=0, idx_q=0, out_valid=0, out_eq=0, out_idx=0, pass_cnt=0, fail_cnt=0. in_ready is 1 from the first cycle after rst_n deasserts.
- IDLE: in_ready=1.
  - Acceptance edge e0 (in_valid & in_ready): capture a_q/b_q; ptr=0, mism=0, idx_q=0; go to CMP.
- CMP: in_ready=0.
  - Each cycle the slice compares a_q/b_q bits [ptr*CHUNK +: CHUNK].
  - On the first mismatch (mism=0): idx_q = ptr*CHUNK + lowest differing bit in the chunk; mism=1. Later mismatches never overwrite idx_q.
  - EARLY_EXIT=1 and a mismatch this cycle → DONE.
  - Otherwise, ptr==K-1 → DONE; else ptr+1.
  - Chunk j is compared in the cycle after edge e0+j.
  - Full sweep: out_valid rises after edge e0+K. Early exit at chunk j: out_valid rises after edge e0+j+1.
- DONE: out_valid=1, out_eq=~mism, out_idx=idx_q, held stable until out_ready.
  - On out_valid & out_ready: increment pass_cnt or fail_cnt (saturating at 2^CNT_W-1, no wrap); go to IDLE.
  - No back-to-back acceptance: in_ready is 0 in DONE.
- flush:
  - In CMP or DONE: next state IDLE, out_valid drops, counters unchanged, the result is discarded.
  - flush outranks out_ready in the same cycle: no count.
  - flush in IDLE outranks in_valid: nothing is accepted that cycle.
- Reset mid-operation: immediate return to the reset values; the job is lost.
- Inputs in_a/in_b are sampled only at acceptance; later changes are ignored.

Decomposition:
- Shared package mirror_pkg:
  - state enum {IDLE, CMP, DONE};
  - localparam function for the index width ($clog2(N));
  - the N % CHUNK == 0 check helper.
- Sub-module mirror_slice_eq (combinational, CHUNK wide):
  - outputs eq and a priority-encoded lowest differing-bit offset;
  - instanced once and shared across all chunks.

Test Plan (N=20, CHUNK=4, CNT_W=16 unless noted):
- Equal vectors: in_a=in_b=20'hABCDE, EARLY_EXIT=1, accept at e0 → out_valid after e0+5, out_eq=1, out_idx=0, pass_cnt=1.
- Single mismatch, early exit: in_a=20'h00000, in_b=20'h00100 (bit 8), EARLY_EXIT=1 → out_valid after e0+3, out_eq=0, out_idx=8, fail_cnt=1.
- Multiple mismatches, full sweep: bits 3 and 17 differ, EARLY_EXIT=0 → out_valid after e0+5, out_idx=3.
- Backpressure: out_ready low for 4 cycles in DONE → out_valid/out_eq/out_idx stable, in_ready=0, counters unchanged; counter increments only on the out_ready cycle.
- Flush and reset:
  - flush pulsed in CMP at e0+2 → IDLE next cycle, no out_valid, counters unchanged.
  - rst_n pulsed low mid-CMP → all outputs 0 immediately; in_ready=1 after release.
- Saturation: CNT_W=2, 5 equal jobs → pass_cnt reaches 3 and stays 3; fail_cnt=0.
